wishbone_arbiter: RTL and testbench

- Two-master, one-slave Wishbone arbiter that shares the peripheral bus driven by the host command master with a second requester, such as a DMA engine.
- Sits between the masters and the bus interconnect. Grants whole cycles: ownership is held for as long as the owner holds cyc.
- Uses round-robin priority on contention.
- A watchdog terminates any cycle whose slave never acks, so the host command path cannot hang.

---
 rtl/mg_arb_pkg.sv | 26 ++
 rtl/wb_watchdog.sv | 32 +++
 rtl/wishbone_arbiter.sv | 164 ++++++++++++++++
 tb/tb_wishbone_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mg_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// Latency: none (declarations only); backpressure: not applicable.
package mg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        TERM = 2'd3
    } arb_state_t;

    localparam int          NUM_MASTERS = 2;
    localparam logic [31:0] TERM_DATA   = 32'hFFFF_FFFF;

    // One master's request bundle, muxed as a unit onto the slave side.
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        stb;
        logic        cyc;
        logic        we;
        logic        msk;
    } wb_req_t;

endpackage

// File: rtl/wb_watchdog.sv
// Counts strobed, un-acked bus cycles and fires on the last one before TIMEOUT.
// Latency: fire is combinational from the count; backpressure: none, clear wins over counting.
module wb_watchdog #(
    parameter int TIMEOUT  = 1024,
    parameter int TO_WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic fire
);

    localparam logic [TO_WIDTH-1:0] LIMIT = TO_WIDTH'(TIMEOUT);
    localparam logic [TO_WIDTH-1:0] LAST  = LIMIT - TO_WIDTH'(1);

    logic [TO_WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + TO_WIDTH'(1);
        end
    end

    // TIMEOUT of 0 disables the watchdog entirely.
    assign fire = (TIMEOUT != 0) && enable && !clear && (count == LAST);

endmodule

// File: rtl/wishbone_arbiter.sv
// Two-master round-robin Wishbone arbiter granting whole cyc periods, with ack watchdog.
// Latency: 1-cycle grant, combinational data path; backpressure: losing master waits on cyc.
module wishbone_arbiter
    import mg_arb_pkg::*;
#(
    parameter int TIMEOUT  = 1024,
    parameter int TO_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            m0_adr_i,
    input  logic [31:0]            m0_dat_i,
    input  logic                   m0_stb_i,
    input  logic                   m0_cyc_i,
    input  logic                   m0_we_i,
    input  logic                   m0_msk_i,
    input  logic [3:0]             m0_sel_i,
    output logic [31:0]            m0_dat_o,
    output logic                   m0_ack_o,
    output logic                   m0_int_o,
    input  logic [31:0]            m1_adr_i,
    input  logic [31:0]            m1_dat_i,
    input  logic                   m1_stb_i,
    input  logic                   m1_cyc_i,
    input  logic                   m1_we_i,
    input  logic                   m1_msk_i,
    input  logic [3:0]             m1_sel_i,
    output logic [31:0]            m1_dat_o,
    output logic                   m1_ack_o,
    output logic                   m1_int_o,
    output logic [31:0]            s_adr_o,
    output logic [31:0]            s_dat_o,
    output logic                   s_stb_o,
    output logic                   s_cyc_o,
    output logic                   s_we_o,
    output logic                   s_msk_o,
    output logic [3:0]             s_sel_o,
    input  logic [31:0]            s_dat_i,
    input  logic                   s_ack_i,
    input  logic                   s_int_i,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic                   timeout_o
);

    arb_state_t state, state_nxt;
    logic       last_owner, last_owner_nxt;
    logic       term_owner;
    logic       term_first;
    logic       wd_fire;
    logic       own_stb;
    wb_req_t    req0, req1, bus;

    assign req0 = '{adr: m0_adr_i, dat: m0_dat_i, sel: m0_sel_i, stb: m0_stb_i,
                    cyc: m0_cyc_i, we: m0_we_i, msk: m0_msk_i};
    assign req1 = '{adr: m1_adr_i, dat: m1_dat_i, sel: m1_sel_i, stb: m1_stb_i,
                    cyc: m1_cyc_i, we: m1_we_i, msk: m1_msk_i};

    // Derived from raw inputs rather than the muxed bus to keep fire free of loops.
    assign own_stb = ((state == OWN0) && m0_stb_i) || ((state == OWN1) && m1_stb_i);

    wb_watchdog #(
        .TIMEOUT  (TIMEOUT),
        .TO_WIDTH (TO_WIDTH)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (s_ack_i || !own_stb),
        .enable ((state == OWN0) || (state == OWN1)),
        .fire   (wd_fire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            term_owner <= 1'b0;
            term_first <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            term_first <= (state_nxt == TERM) && (state != TERM);
            if ((state_nxt == TERM) && (state != TERM)) begin
                term_owner <= (state == OWN1);
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        bus            = '0;
        grant_o        = '0;
        m0_ack_o       = 1'b0;
        m1_ack_o       = 1'b0;
        timeout_o      = 1'b0;
        m0_dat_o       = s_dat_i;
        m1_dat_o       = s_dat_i;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_nxt = last_owner ? OWN0 : OWN1;
                end else if (m0_cyc_i) begin
                    state_nxt = OWN0;
                end else if (m1_cyc_i) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                bus      = req0;
                grant_o  = 2'b01;
                m0_ack_o = s_ack_i;
                if (!m0_cyc_i) begin
                    state_nxt      = IDLE;
                    last_owner_nxt = 1'b0;
                end else if (wd_fire) begin
                    state_nxt = TERM;
                end
            end
            OWN1: begin
                bus      = req1;
                grant_o  = 2'b10;
                m1_ack_o = s_ack_i;
                if (!m1_cyc_i) begin
                    state_nxt      = IDLE;
                    last_owner_nxt = 1'b1;
                end else if (wd_fire) begin
                    state_nxt = TERM;
                end
            end
            TERM: begin
                // Slave is released; owner gets a single error-data ack on entry.
                bus     = term_owner ? req1 : req0;
                bus.stb = 1'b0;
                bus.cyc = 1'b0;
                grant_o = term_owner ? 2'b10 : 2'b01;
                if (term_first) begin
                    timeout_o = 1'b1;
                    if (term_owner) begin
                        m1_ack_o = 1'b1;
                        m1_dat_o = TERM_DATA;
                    end else begin
                        m0_ack_o = 1'b1;
                        m0_dat_o = TERM_DATA;
                    end
                end
                if (!(term_owner ? m1_cyc_i : m0_cyc_i)) begin
                    state_nxt      = IDLE;
                    last_owner_nxt = term_owner;
                end
            end
        endcase
    end

    assign s_adr_o  = bus.adr;
    assign s_dat_o  = bus.dat;
    assign s_sel_o  = bus.sel;
    assign s_stb_o  = bus.stb;
    assign s_cyc_o  = bus.cyc;
    assign s_we_o   = bus.we;
    assign s_msk_o  = bus.msk;
    assign m0_int_o = s_int_i;
    assign m1_int_o = s_int_i;

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed vector bench for wishbone_arbiter: arbitration table plus timeout, burst and reset sequences.
module tb_wishbone_arbiter;

    logic        clk, rst;
    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i, s_dat_i;
    logic        m0_stb_i, m0_cyc_i, m0_we_i, m0_msk_i;
    logic        m1_stb_i, m1_cyc_i, m1_we_i, m1_msk_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
    logic        m0_ack_o, m0_int_o, m1_ack_o, m1_int_o;
    logic        s_stb_o, s_cyc_o, s_we_o, s_msk_o, s_ack_i, s_int_i, timeout_o;
    logic [3:0]  s_sel_o;
    logic [1:0]  grant_o;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] D0 = 32'hCAFE_F00D;
    localparam logic [31:0] D1 = 32'h1234_5678;

    wishbone_arbiter #(.TIMEOUT(16), .TO_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i),
        .m0_we_i(m0_we_i), .m0_msk_i(m0_msk_i), .m0_sel_i(m0_sel_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_int_o(m0_int_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i),
        .m1_we_i(m1_we_i), .m1_msk_i(m1_msk_i), .m1_sel_i(m1_sel_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_int_o(m1_int_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
        .s_we_o(s_we_o), .s_msk_o(s_msk_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_int_i(s_int_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        c0, s0, w0;
        logic [31:0] a0;
        logic        c1, s1;
        logic [31:0] a1;
        logic        ack, irq;
        logic [31:0] sdat;
        logic [1:0]  e_gnt;
        logic        e_cyc, e_stb, e_we, e_ack0, e_ack1;
    } vec_t;

    function automatic vec_t mk(input logic c0, s0, w0, input logic [31:0] a0,
                                input logic c1, s1, input logic [31:0] a1,
                                input logic ack, irq, input logic [31:0] sdat,
                                input logic [1:0] eg, input logic ec, es, ew, ea0, ea1);
        vec_t v;
        v = '{c0, s0, w0, a0, c1, s1, a1, ack, irq, sdat, eg, ec, es, ew, ea0, ea1};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c0, s0, w0, input logic [31:0] a0,
                         input logic c1, s1, input logic [31:0] a1, input logic ack);
        m0_cyc_i = c0; m0_stb_i = s0; m0_we_i = w0; m0_adr_i = a0;
        m1_cyc_i = c1; m1_stb_i = s1; m1_adr_i = a1; s_ack_i = ack;
    endtask

    vec_t vecs[25];

    initial begin
        logic [31:0] e_adr, e_dat;
        logic [3:0]  e_sel;
        int          early;

        // Arbitration after reset, m0-only write, then a repeated contention.
        vecs[0]  = mk(1,1,0,32'h200, 1,1,32'h300, 0,0,32'h0,        2'b00,0,0,0,0,0);
        vecs[1]  = mk(1,1,0,32'h200, 1,1,32'h300, 0,0,32'h0,        2'b01,1,1,0,0,0);
        vecs[2]  = mk(1,1,0,32'h200, 1,1,32'h300, 1,1,32'hA5A5A5A5, 2'b01,1,1,0,1,0);
        vecs[3]  = mk(0,0,0,32'h200, 1,1,32'h300, 0,0,32'h0,        2'b01,0,0,0,0,0);
        vecs[4]  = mk(0,0,0,32'h200, 1,1,32'h300, 0,1,32'h0,        2'b00,0,0,0,0,0);
        vecs[5]  = mk(0,0,0,32'h200, 1,1,32'h300, 0,0,32'h0,        2'b10,1,1,0,0,0);
        vecs[6]  = mk(0,0,0,32'h200, 1,1,32'h300, 1,0,32'h5A5A5A5A, 2'b10,1,1,0,0,1);
        vecs[7]  = mk(0,0,0,32'h200, 0,0,32'h300, 0,0,32'h0,        2'b10,0,0,0,0,0);
        vecs[8]  = mk(0,0,0,32'h200, 0,0,32'h300, 1,0,32'h0,        2'b00,0,0,0,0,0);
        vecs[9]  = mk(1,1,1,32'h100, 0,0,32'h300, 0,0,32'h0,        2'b00,0,0,0,0,0);
        vecs[10] = mk(1,1,1,32'h100, 0,0,32'h300, 0,0,32'h0,        2'b01,1,1,1,0,0);
        vecs[11] = mk(1,1,1,32'h100, 0,0,32'h300, 0,0,32'h0,        2'b01,1,1,1,0,0);
        vecs[12] = mk(1,1,1,32'h100, 0,0,32'h300, 0,0,32'h0,        2'b01,1,1,1,0,0);
        vecs[13] = mk(1,1,1,32'h100, 0,0,32'h300, 1,0,32'hDEADBEEF, 2'b01,1,1,1,1,0);
        vecs[14] = mk(0,0,0,32'h100, 0,0,32'h300, 0,0,32'h0,        2'b01,0,0,0,0,0);
        vecs[15] = mk(0,0,0,32'h100, 0,0,32'h300, 0,0,32'h0,        2'b00,0,0,0,0,0);
        vecs[16] = mk(1,1,0,32'h200, 1,1,32'h300, 0,0,32'h0,        2'b00,0,0,0,0,0);
        vecs[17] = mk(1,1,0,32'h200, 1,1,32'h300, 0,0,32'h0,        2'b10,1,1,0,0,0);
        vecs[18] = mk(1,1,0,32'h200, 1,1,32'h300, 1,0,32'h11111111, 2'b10,1,1,0,0,1);
        vecs[19] = mk(1,1,0,32'h200, 0,0,32'h300, 0,0,32'h0,        2'b10,0,0,0,0,0);
        vecs[20] = mk(1,1,0,32'h200, 0,0,32'h300, 0,0,32'h0,        2'b00,0,0,0,0,0);
        vecs[21] = mk(1,1,0,32'h200, 0,0,32'h300, 0,0,32'h0,        2'b01,1,1,0,0,0);
        vecs[22] = mk(1,1,0,32'h200, 0,0,32'h300, 1,0,32'h22222222, 2'b01,1,1,0,1,0);
        vecs[23] = mk(0,0,0,32'h200, 0,0,32'h300, 0,0,32'h0,        2'b01,0,0,0,0,0);
        vecs[24] = mk(0,0,0,32'h200, 0,0,32'h300, 0,0,32'h0,        2'b00,0,0,0,0,0);

        rst = 1'b0;
        m0_dat_i = D0; m1_dat_i = D1; m0_sel_i = 4'hF; m1_sel_i = 4'h3;
        m0_msk_i = 1'b0; m1_msk_i = 1'b0; m1_we_i = 1'b0;
        s_dat_i = 32'h0; s_int_i = 1'b0;
        drive(1, 1, 1, 32'h100, 1, 1, 32'h300, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_timeout", 32'(timeout_o), 32'h0);
        chk("rst_s_ctl", {26'h0, s_stb_o, s_cyc_o, s_we_o, s_msk_o, s_sel_o != 4'h0, 1'b0}, 32'h0);
        chk("rst_s_adr", s_adr_o, 32'h0);
        chk("rst_s_dat", s_dat_o, 32'h0);
        chk("rst_acks", {30'h0, m0_ack_o, m1_ack_o}, 32'h0);
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].c0, vecs[i].s0, vecs[i].w0, vecs[i].a0,
                  vecs[i].c1, vecs[i].s1, vecs[i].a1, vecs[i].ack);
            s_int_i = vecs[i].irq;
            s_dat_i = vecs[i].sdat;
            #2;
            e_adr = (vecs[i].e_gnt == 2'b01) ? vecs[i].a0 : (vecs[i].e_gnt == 2'b10) ? vecs[i].a1 : 32'h0;
            e_dat = (vecs[i].e_gnt == 2'b01) ? D0 : (vecs[i].e_gnt == 2'b10) ? D1 : 32'h0;
            e_sel = (vecs[i].e_gnt == 2'b01) ? 4'hF : (vecs[i].e_gnt == 2'b10) ? 4'h3 : 4'h0;
            chk($sformatf("v%0d_grant", i), 32'(grant_o), 32'(vecs[i].e_gnt));
            chk($sformatf("v%0d_s_ctl", i), {29'h0, s_cyc_o, s_stb_o, s_we_o},
                {29'h0, vecs[i].e_cyc, vecs[i].e_stb, vecs[i].e_we});
            chk($sformatf("v%0d_s_adr", i), s_adr_o, e_adr);
            chk($sformatf("v%0d_s_dat", i), s_dat_o, e_dat);
            chk($sformatf("v%0d_s_sel", i), 32'(s_sel_o), 32'(e_sel));
            chk($sformatf("v%0d_acks", i), {30'h0, m0_ack_o, m1_ack_o},
                {30'h0, vecs[i].e_ack0, vecs[i].e_ack1});
            chk($sformatf("v%0d_rdata", i), m0_dat_o ^ m1_dat_o ^ vecs[i].sdat, vecs[i].sdat);
            chk($sformatf("v%0d_int", i), {30'h0, m0_int_o, m1_int_o}, {30'h0, vecs[i].irq, vecs[i].irq});
            step();
        end
        s_int_i = 1'b0;
        s_dat_i = 32'h0;

        // m1 read that the slave never acks: watchdog after 16 strobed cycles.
        drive(0, 0, 0, 32'h0, 1, 1, 32'h400, 0);
        #2;
        chk("to_idle_grant", 32'(grant_o), 32'h0);
        step();
        early = 0;
        for (int j = 0; j < 16; j++) begin
            #1;
            if (m1_ack_o !== 1'b0 || timeout_o !== 1'b0 || s_stb_o !== 1'b1) early++;
            step();
        end
        chk("to_no_early_ack", 32'(early), 32'h0);
        #2;
        chk("to_ack", {30'h0, m0_ack_o, m1_ack_o}, 32'h1);
        chk("to_dat", m1_dat_o, 32'hFFFF_FFFF);
        chk("to_pulse", 32'(timeout_o), 32'h1);
        chk("to_bus_off", {30'h0, s_cyc_o, s_stb_o}, 32'h0);
        step();
        #2;
        chk("to_ack_once", {30'h0, m1_ack_o, timeout_o}, 32'h0);
        chk("to_term_hold", {29'h0, s_cyc_o, grant_o}, 32'h2);
        drive(0, 0, 0, 32'h0, 0, 0, 32'h400, 0);
        step();
        step();
        #2;
        chk("to_back_idle", 32'(grant_o), 32'h0);

        // m1 4-beat burst while m0 waits.
        drive(0, 0, 0, 32'h0, 1, 1, 32'h500, 0);
        step();
        #2;
        chk("bu_grant_m1", 32'(grant_o), 32'h2);
        drive(1, 1, 0, 32'h600, 1, 1, 32'h500, 0);
        for (int b = 0; b < 4; b++) begin
            s_ack_i = 1'b1;
            #2;
            chk($sformatf("bu_beat%0d", b), {28'h0, m0_ack_o, m1_ack_o, grant_o}, 32'h6);
            step();
            s_ack_i = 1'b0;
            #2;
            chk($sformatf("bu_gap%0d", b), {28'h0, m0_ack_o, m1_ack_o, grant_o}, 32'h2);
            step();
        end
        drive(1, 1, 0, 32'h600, 0, 0, 32'h500, 0);
        #2;
        chk("bu_drop_hold", 32'(grant_o), 32'h2);
        step();
        #2;
        chk("bu_idle_gap", 32'(grant_o), 32'h0);
        step();
        #2;
        chk("bu_m0_grant", 32'(grant_o), 32'h1);
        chk("bu_m0_adr", s_adr_o, 32'h600);

        // Asynchronous reset while m0 owns the bus with stb high.
        s_ack_i = 1'b1;
        rst = 1'b0;
        #1;
        chk("ar_bus_off", {30'h0, s_cyc_o, s_stb_o}, 32'h0);
        chk("ar_grant", 32'(grant_o), 32'h0);
        chk("ar_no_ack", {30'h0, m0_ack_o, m1_ack_o}, 32'h0);
        drive(0, 0, 0, 32'h0, 1, 1, 32'h700, 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        #2;
        chk("ar_m1_grant", 32'(grant_o), 32'h2);
        chk("ar_m1_adr", s_adr_o, 32'h700);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
